text_console_writer: RTL
========================

Name: text_console_writer

Overview:
Writer side of the 70x30 character buffer that the VGA text display reads. It accepts a byte stream over a valid/ready handshake and interprets each byte as a printable character or a control code. It keeps a cursor and writes ASCII codes into the dual-port character RAM through that RAM's write port. It performs line wrap, backspace, clear-screen and hardware scroll; scroll copies rows through a second RAM read port.

Parameters:
COLS, 70, characters per row
ROWS, 30, rows on screen
ADDR_W, 12, character RAM address width
BLANK, 8'h00, code written to erased cells (the display renders 0 as background)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
clrn  input  1  asynchronous active-low reset
char_valid  input  1  byte offered
char_data  input  8  byte value
char_ready  output  1  writer can accept a byte
wraddress  output  ADDR_W  RAM write address, x + y*COLS
wrdata  output  8  RAM write data
wren  output  1  RAM write enable, one-cycle pulses
rdaddress  output  ADDR_W  RAM read address, used only during scroll
q  input  8  RAM read data, valid one clk after rdaddress
cur_x  output  7  cursor column, 0..COLS-1
cur_y  output  5  cursor row, 0..ROWS-1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, clrn=0): state IDLE, cur_x=0, cur_y=0, wren=0, wraddress=0, wrdata=0, rdaddress=0. char_ready=1 once clrn deasserts, unless the optional feature is enabled.
- All outputs are registered. char_ready = (state==IDLE). A byte is accepted on the edge where char_valid & char_ready.
- States: IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLR.
- Printable byte 0x20..0x7E accepted at edge N:
  - wren=1 during cycle N+1, with wraddress = cur_x + cur_y*70 and wrdata = byte.
  - Cursor advances at edge N+1.
  - If cur_x was 69: cur_x=0 and cur_y+1.
  - If cur_y was 29 on that wrap: enter SCR_RD instead of IDLE.
  - Throughput is one byte per 2 clks.
- 0x0A (LF): cur_x=0, cur_y+1. At row 29, enter scroll instead. No write.
- 0x0D (CR): cur_x=0. No write.
- 0x08 (BS):
  - cur_x>0: cur_x-1, then write BLANK at the new position.
  - cur_x=0 and cur_y>0: move to (69, cur_y-1), then write BLANK there.
  - At (0,0): no write, no move.
- 0x0C (FF): CLR writes BLANK to addresses 0..2099, one per clk, ascending. Then cursor goes to (0,0) and state returns to IDLE. 2100 busy cycles.
- All other bytes are accepted and ignored, with no write and no cursor change.
- Scroll, for dst = 0..2029:
  - SCR_RD drives rdaddress = dst+70.
  - SCR_WR writes q to wraddress = dst.
  - SCR_CLR then writes BLANK to 2030..2099.
  - End state: cursor (0,29), IDLE.
  - Total busy = 2*2030 + 70 = 4130 clks.
- Scroll and clear sequences are not interruptible. Bytes offered while busy wait because char_ready=0. Only clrn aborts a sequence; it resets immediately, leaving partial RAM content as-is.
- Address arithmetic is in ADDR_W bits. The y*COLS product never exceeds 2099.

Optional Feature:
TEXT_CLEAR_ON_RESET_EN
- Defined: after clrn deasserts, the block enters CLR, so the first 2100 clks write BLANK everywhere with char_ready=0. Cursor then (0,0) and state IDLE.
- Undefined: the block enters IDLE directly and RAM content is untouched.

Test Plan:
- Reset release, send 0x41 -> one wren pulse: wraddress=0, wrdata=0x41. Then cur_x=1, cur_y=0, char_ready back to 1 two clks after accept.
- 70 x 0x42 from (0,0) -> writes at addresses 0..69. Cursor ends (0,1) with no scroll.
- Fill rows 0..29 with row index + 0x30, cursor (5,29), send 0x0A -> busy for 4130 clks. RAM model: row r holds 0x31+r for r=0..28, row 29 all 0x00. Cursor (0,29).
- Cursor (0,1), send 0x08 -> single write of 0x00 at address 69, cursor (69,0). Repeat from (0,0) -> no wren, cursor unchanged.
- Send 0x0C -> 2100 consecutive wren pulses covering 0..2099 with 0x00, then cursor (0,0). Send 0x07 -> no wren, cursor unchanged.
- Pull clrn low mid-scroll (cycle 1000) -> same-instant wren=0, cursor (0,0). char_ready=1 after release (feature off).

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream writer for the 70x30 VGA text RAM.
// Define TEXT_CLEAR_ON_RESET_EN to blank the whole RAM after every reset.
module text_console_writer #(
  parameter int         COLS   = 70,
  parameter int         ROWS   = 30,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] BLANK  = 8'h00
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        wrdata,
  output logic              wren,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [7:0]        q,
  output logic [6:0]        cur_x,
  output logic [4:0]        cur_y,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUT     = 3'd1;
  localparam logic [2:0] S_SCR_RD  = 3'd2;
  localparam logic [2:0] S_SCR_WR  = 3'd3;
  localparam logic [2:0] S_SCR_CLR = 3'd4;
  localparam logic [2:0] S_CLR     = 3'd5;

`ifdef TEXT_CLEAR_ON_RESET_EN
  localparam logic [2:0] S_RST = S_CLR;
`else
  localparam logic [2:0] S_RST = S_IDLE;
`endif

  localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] NXT_SRC  = ADDR_W'(COLS + 1);
  localparam logic [ADDR_W-1:0] SCR_N    = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(COLS * (ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] CELL_LST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        X_MAX    = 7'(COLS - 1);
  localparam logic [4:0]        Y_MAX    = 5'(ROWS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [6:0]        cur_x_q, cur_x_d;
  logic [4:0]        cur_y_q, cur_y_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic [7:0]        wrdata_q, wrdata_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] pos;
  logic              is_print;
  logic              scroll_go;

  assign pos = ADDR_W'(cur_x_q) + ADDR_W'(cur_y_q) * ROW_W;
  assign is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    wraddress_d = wraddress_q;
    wrdata_d    = wrdata_q;
    wren_d      = 1'b0;
    rdaddress_d = rdaddress_q;
    scroll_go   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (char_valid) begin
          unique case (1'b1)
            is_print: begin
              wren_d      = 1'b1;
              wraddress_d = pos;
              wrdata_d    = char_data;
              state_d     = S_PUT;
            end
            char_data == 8'h0A: begin
              cur_x_d = '0;
              if (cur_y_q == Y_MAX) scroll_go = 1'b1;
              else cur_y_d = cur_y_q + 5'd1;
            end
            char_data == 8'h0D: cur_x_d = '0;
            char_data == 8'h08: begin
              // both backspace cases land on the cell just before pos
              if (cur_x_q != '0 || cur_y_q != '0) begin
                wren_d      = 1'b1;
                wraddress_d = pos - ADDR_W'(1);
                wrdata_d    = BLANK;
                if (cur_x_q != '0) begin
                  cur_x_d = cur_x_q - 7'd1;
                end else begin
                  cur_x_d = X_MAX;
                  cur_y_d = cur_y_q - 5'd1;
                end
              end
            end
            char_data == 8'h0C: begin
              state_d = S_CLR;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_PUT: begin
        state_d = S_IDLE;
        if (cur_x_q == X_MAX) begin
          cur_x_d = '0;
          if (cur_y_q == Y_MAX) scroll_go = 1'b1;
          else cur_y_d = cur_y_q + 5'd1;
        end else begin
          cur_x_d = cur_x_q + 7'd1;
        end
      end
      S_SCR_RD: state_d = S_SCR_WR;
      S_SCR_WR: begin
        // q holds the cell read from rdaddress during S_SCR_RD
        wren_d      = 1'b1;
        wraddress_d = cnt_q;
        wrdata_d    = q;
        if (cnt_q == SCR_LAST) begin
          state_d = S_SCR_CLR;
          cnt_d   = SCR_N;
        end else begin
          state_d     = S_SCR_RD;
          cnt_d       = cnt_q + ADDR_W'(1);
          rdaddress_d = cnt_q + NXT_SRC;
        end
      end
      S_SCR_CLR, S_CLR: begin
        wren_d      = 1'b1;
        wraddress_d = cnt_q;
        wrdata_d    = BLANK;
        if (cnt_q == CELL_LST) begin
          state_d = S_IDLE;
          cur_x_d = '0;
          cur_y_d = (state_q == S_CLR) ? 5'd0 : Y_MAX;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (scroll_go) begin
      state_d     = S_SCR_RD;
      cnt_d       = '0;
      rdaddress_d = ROW_W;
    end
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      wraddress_q <= '0;
      wrdata_q    <= '0;
      wren_q      <= 1'b0;
      rdaddress_q <= '0;
      ready_q     <= (S_RST == S_IDLE);
      busy_q      <= (S_RST != S_IDLE);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      wraddress_q <= wraddress_d;
      wrdata_q    <= wrdata_d;
      wren_q      <= wren_d;
      rdaddress_q <= rdaddress_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign wraddress  = wraddress_q;
  assign wrdata     = wrdata_q;
  assign wren       = wren_q;
  assign rdaddress  = rdaddress_q;

endmodule
